// File: rtl/ram_rd_chk.sv
// ram_rd_chk: read-back checker for the two-port RAM test design.
//
// Delays the RAM read-port control by the RAM read latency so that each valid
// sample lines up with its returned data word, then compares the word against
// the write pattern (addr + DATA_OFFSET). Counts words and mismatches, keeps
// the first mismatch, and flags done/pass.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rd_flag      one-cycle pulse: write pass finished, arm the checker
//   ram_rd_en    RAM port B read enable
//   ram_rd_addr  RAM port B read address
//   ram_rd_data  RAM port B read data (RD_LAT clocks after the address)
//   chk_busy     checking in progress
//   chk_done     pass finished
//   chk_pass     pass finished with no mismatches
//   word_cnt     words compared this pass
//   err_cnt      mismatches this pass
//   err_addr     address of the first mismatch
//   err_exp      expected data at the first mismatch
//   err_got      received data at the first mismatch

module ram_rd_chk #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned DATA_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_flag,
    input  logic              ram_rd_en,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              chk_busy,
    output logic              chk_done,
    output logic              chk_pass,
    output logic [ADDR_W:0]   word_cnt,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got
);

    localparam int unsigned CntW  = ADDR_W + 1;
    localparam int unsigned EntW  = ADDR_W + 1;
    localparam int unsigned PipeW = RD_LAT * EntW;

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Alignment pipeline, packed as RD_LAT entries of {en, addr}; newest entry
    // in the low bits, oldest (aligned with ram_rd_data) in the high bits.
    logic [PipeW-1:0] pipe_q, pipe_d;

    logic              smp_vld;
    logic [ADDR_W-1:0] smp_addr;
    logic [DATA_W-1:0] exp_data;

    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [CntW-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_got_q, err_got_d;
    logic              first_err_q, first_err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    // Shift by one entry; the cast drops the oldest entry off the top.
    always_comb begin
        pipe_d = PipeW'({pipe_q, ram_rd_en, ram_rd_addr});
    end

    assign smp_vld  = pipe_q[PipeW-1];
    assign smp_addr = pipe_q[PipeW-2 -: ADDR_W];

    // Truncation to DATA_W gives the mod 2^DATA_W wrap of the pattern.
    assign exp_data = DATA_W'(smp_addr) + DATA_W'(DATA_OFFSET);

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        first_err_d = first_err_q;

        case (state_q)
            StIdle, StDone: begin
                // Samples are ignored here, even in the cycle rd_flag arrives.
                if (rd_flag) begin
                    word_cnt_d  = '0;
                    err_cnt_d   = '0;
                    err_addr_d  = '0;
                    err_exp_d   = '0;
                    err_got_d   = '0;
                    first_err_d = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (smp_vld) begin
                    word_cnt_d = word_cnt_q + CntW'(1);
                    if (ram_rd_data != exp_data) begin
                        err_cnt_d = err_cnt_q + CntW'(1);
                        if (!first_err_q) begin
                            err_addr_d  = smp_addr;
                            err_exp_d   = exp_data;
                            err_got_d   = ram_rd_data;
                            first_err_d = 1'b1;
                        end
                    end
                    if (word_cnt_d == DepthCnt) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Flags derive from the next state so they are registered alongside
        // the counters; pass uses the final error count, never a stale one.
        busy_d = (state_d == StCheck);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pipe_q      <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            first_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pipe_q      <= pipe_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            first_err_q <= first_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign chk_busy = busy_q;
    assign chk_done = done_q;
    assign chk_pass = pass_q;
    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;

endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: two instances (RD_LAT=1 and RD_LAT=2) share the read
// control and see a RAM model with matching latency and optional corruption.

module tb_ram_rd_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_flag = 1'b0;
    logic       ram_rd_en = 1'b0;
    logic [5:0] ram_rd_addr = '0;
    logic [7:0] rdata1, rdata2;
    logic [7:0] mem [64];

    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [6:0] wcnt [2];
    logic [6:0] ecnt [2];
    logic [5:0] eaddr [2];
    logic [7:0] eexp [2];
    logic [7:0] egot [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rdata1 <= mem[ram_rd_addr];
        rdata2 <= rdata1;
    end

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .DEPTH(64), .RD_LAT(1), .DATA_OFFSET(0)) u_lat1 (
        .clk         (clk),
        .rst         (rst),
        .rd_flag     (rd_flag),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (rdata1),
        .chk_busy    (busy[0]),
        .chk_done    (done[0]),
        .chk_pass    (pass[0]),
        .word_cnt    (wcnt[0]),
        .err_cnt     (ecnt[0]),
        .err_addr    (eaddr[0]),
        .err_exp     (eexp[0]),
        .err_got     (egot[0])
    );

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .DEPTH(64), .RD_LAT(2), .DATA_OFFSET(0)) u_lat2 (
        .clk         (clk),
        .rst         (rst),
        .rd_flag     (rd_flag),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (rdata2),
        .chk_busy    (busy[1]),
        .chk_done    (done[1]),
        .chk_pass    (pass[1]),
        .word_cnt    (wcnt[1]),
        .err_cnt     (ecnt[1]),
        .err_addr    (eaddr[1]),
        .err_exp     (eexp[1]),
        .err_got     (egot[1])
    );

    typedef struct {
        string      name;
        bit         gap;
        int         c0_a;
        logic [7:0] c0_v;
        int         c1_a;
        logic [7:0] c1_v;
        logic [6:0] w;
        logic [6:0] e;
        logic [5:0] ea;
        logic [7:0] ex;
        logic [7:0] eg;
        logic       p;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic mem_init();
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_flag = 1'b0;
        ram_rd_en = 1'b0;
        ram_rd_addr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic by, input logic dn, input logic ps,
                             input logic [6:0] w, input logic [6:0] e, input logic [5:0] ea,
                             input logic [7:0] ex, input logic [7:0] eg);
        for (int d = 0; d < 2; d++) begin
            string t;
            t = $sformatf("%s/lat%0d", tag, d + 1);
            chk({t, " busy"}, 32'(busy[d]), 32'(by));
            chk({t, " done"}, 32'(done[d]), 32'(dn));
            chk({t, " pass"}, 32'(pass[d]), 32'(ps));
            chk({t, " word_cnt"}, 32'(wcnt[d]), 32'(w));
            chk({t, " err_cnt"}, 32'(ecnt[d]), 32'(e));
            chk({t, " err_addr"}, 32'(eaddr[d]), 32'(ea));
            chk({t, " err_exp"}, 32'(eexp[d]), 32'(ex));
            chk({t, " err_got"}, 32'(egot[d]), 32'(eg));
        end
    endtask

    // Reads issued in IDLE; the last one lands in the rd_flag cycle on lat2.
    task automatic pre_reads_and_arm(input string tag);
        for (int i = 0; i < 4; i++) begin
            ram_rd_en = 1'b1;
            ram_rd_addr = 6'(40 + i);
            step();
        end
        ram_rd_en = 1'b0;
        step();
        chk({tag, " idle word_cnt lat1"}, 32'(wcnt[0]), 32'd0);
        rd_flag = 1'b1;
        step();
        rd_flag = 1'b0;
        chk({tag, " arm busy lat1"}, 32'(busy[0]), 32'd1);
        chk({tag, " arm busy lat2"}, 32'(busy[1]), 32'd1);
        chk({tag, " arm word_cnt lat2"}, 32'(wcnt[1]), 32'd0);
    endtask

    // Issues n reads of addr 0..n-1; disabled gap cycles carry a decoy address.
    task automatic run_reads(input bit gap, input int n, input int flag_at);
        for (int i = 0; i < n; i++) begin
            ram_rd_en = 1'b1;
            ram_rd_addr = 6'(i);
            if (i == flag_at) rd_flag = 1'b1;
            step();
            rd_flag = 1'b0;
            if (gap) begin
                ram_rd_en = 1'b0;
                ram_rd_addr = 6'(63 - i);
                step();
            end
        end
        ram_rd_en = 1'b0;
    endtask

    // After a full pass: lat1 finishes 2 edges after the last read, lat2 after 3.
    task automatic finish_pass(input string tag, input bit gap);
        for (int s = (gap ? 2 : 1); s <= 3; s++) begin
            chk($sformatf("%s done lat1 s%0d", tag, s), 32'(done[0]), 32'(s >= 2));
            chk($sformatf("%s done lat2 s%0d", tag, s), 32'(done[1]), 32'(s >= 3));
            if (s < 3) step();
        end
    endtask

    initial begin
        vecs[0] = '{"clean",    1'b0, -1, 8'h00, -1, 8'h00, 7'd64, 7'd0, 6'h00, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{"single",   1'b0, 21, 8'hFF, -1, 8'h00, 7'd64, 7'd1, 6'h15, 8'h15, 8'hFF, 1'b0};
        vecs[2] = '{"firsterr", 1'b0,  5, 8'hAA,  9, 8'h00, 7'd64, 7'd2, 6'h05, 8'h05, 8'hAA, 1'b0};
        vecs[3] = '{"gapped",   1'b1, -1, 8'h00, -1, 8'h00, 7'd64, 7'd0, 6'h00, 8'h00, 8'h00, 1'b1};

        mem_init();
        do_reset();
        check_all("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            mem_init();
            if (vecs[v].c0_a >= 0) mem[vecs[v].c0_a] = vecs[v].c0_v;
            if (vecs[v].c1_a >= 0) mem[vecs[v].c1_a] = vecs[v].c1_v;
            pre_reads_and_arm(vecs[v].name);
            run_reads(vecs[v].gap, 64, -1);
            finish_pass(vecs[v].name, vecs[v].gap);
            // Extra reads in DONE, aimed at a corrupted word when there is one.
            for (int i = 0; i < 3; i++) begin
                ram_rd_en = 1'b1;
                ram_rd_addr = (vecs[v].c0_a >= 0) ? 6'(vecs[v].c0_a) : 6'(i);
                step();
            end
            ram_rd_en = 1'b0;
            step();
            step();
            check_all(vecs[v].name, 1'b0, 1'b1, vecs[v].p, vecs[v].w, vecs[v].e,
                      vecs[v].ea, vecs[v].ex, vecs[v].eg);
        end

        // Reset mid-check, then a fresh clean pass.
        do_reset();
        mem_init();
        mem[3] = 8'h77;
        rd_flag = 1'b1;
        step();
        rd_flag = 1'b0;
        run_reads(1'b0, 30, -1);
        step();
        chk("midrst word_cnt before lat1", 32'(wcnt[0]), 32'd30);
        chk("midrst err_cnt before lat1", 32'(ecnt[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("midrst", 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        mem_init();
        step();
        step();
        check_all("midrst idle", 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        rd_flag = 1'b1;
        step();
        rd_flag = 1'b0;
        run_reads(1'b0, 64, -1);
        finish_pass("midrst pass", 1'b0);
        check_all("midrst pass", 1'b0, 1'b1, 1'b1, 7'd64, '0, '0, '0, '0);

        // Failing pass, re-arm from DONE, clean second pass with a stray
        // rd_flag mid-check that must be ignored.
        do_reset();
        mem_init();
        mem[21] = 8'hFF;
        rd_flag = 1'b1;
        step();
        rd_flag = 1'b0;
        run_reads(1'b0, 64, -1);
        finish_pass("rearm fail", 1'b0);
        check_all("rearm fail", 1'b0, 1'b1, 1'b0, 7'd64, 7'd1, 6'h15, 8'h15, 8'hFF);
        mem_init();
        rd_flag = 1'b1;
        step();
        rd_flag = 1'b0;
        check_all("rearm clear", 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        run_reads(1'b0, 64, 10);
        finish_pass("rearm pass", 1'b0);
        check_all("rearm pass", 1'b0, 1'b1, 1'b1, 7'd64, '0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_rd_chk.md
# ram_rd_chk

Read-back checker that sits directly downstream of the RAM read stage in the two-port RAM test design. It consumes the read-port control (enable and address) and the RAM output data, aligns them to the RAM's read latency, and compares each word against the known write pattern (data = address + offset). It reports word and error counts, captures the first mismatch, and raises done/pass flags for LEDs or an ILA.

## Interface
- ADDR_W, 6, RAM address width
- DATA_W, 8, RAM data width
- DEPTH, 64, number of words checked per pass (≤ 2^ADDR_W)
- RD_LAT, 1, RAM read latency in clocks (legal 1 or 2)
- DATA_OFFSET, 0, expected data = (addr + DATA_OFFSET) mod 2^DATA_W

Ports:
- clk  in  1  single system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_flag  in  1  one-cycle pulse from the writer: write pass complete, arm checker
- ram_rd_en  in  1  read enable driven to the RAM port B
- ram_rd_addr  in  ADDR_W  read address driven to the RAM port B
- ram_rd_data  in  DATA_W  RAM port B output data
- chk_busy  out  1  high while in CHECK
- chk_done  out  1  high in DONE
- chk_pass  out  1  high in DONE when err_cnt == 0
- word_cnt  out  ADDR_W+1  words compared this pass
- err_cnt  out  ADDR_W+1  mismatches this pass
- err_addr  out  ADDR_W  address of the first mismatch
- err_exp  out  DATA_W  expected data at the first mismatch
- err_got  out  DATA_W  received data at the first mismatch

## Operation
- Alignment pipeline: a shift register RD_LAT stages deep carries {ram_rd_en, ram_rd_addr}. Its output gives smp_vld/smp_addr, which are aligned to ram_rd_data. The pipeline runs in every state and is cleared by rst.
- FSM states:
  - IDLE: rd_flag=1 clears word_cnt, err_cnt, err_addr, err_exp, err_got and the first-error flag, then moves to CHECK. smp_vld is ignored in IDLE, including in the cycle rd_flag is sampled.
  - CHECK: each cycle with smp_vld=1 compares ram_rd_data against exp = smp_addr + DATA_OFFSET, truncated to DATA_W.
    - word_cnt increments on every compare.
    - err_cnt increments on a mismatch.
    - On the first mismatch of the pass, err_addr, err_exp and err_got are captured and then hold.
    - When the compare that brings word_cnt to DEPTH completes, the FSM moves to DONE.
    - rd_flag is ignored in CHECK.
  - DONE: all counters and capture registers hold, and smp_vld is ignored. rd_flag=1 re-arms: registers clear (as in IDLE) and the FSM moves to CHECK.
- Gaps in ram_rd_en are allowed. Only valid samples count. Addresses need not be sequential; exp is always derived from smp_addr.
- Counters cannot overflow because DEPTH ≤ 2^ADDR_W and they are ADDR_W+1 bits wide. No saturation logic is needed.

## Timing
- Reset values: state=IDLE; all outputs 0; pipeline valids 0.
- Read issued with ram_rd_en=1 at cycle t is compared at cycle t+RD_LAT. Counters update at the next edge (t+RD_LAT+1).
- rd_flag high in cycle a: chk_busy=1 from cycle a+1. A sample is counted only if its smp_vld occurs in cycle ≥ a+1.
- Last (DEPTH-th) compare in cycle c: word_cnt=DEPTH, chk_busy=0 and chk_done=1 from cycle c+1. chk_pass is valid in the same cycle.
- Mismatch on the DEPTH-th word: err_cnt and chk_pass reflect it in cycle c+1. The FSM never shows pass=1 transiently.
- rst=1 in any state (including mid-CHECK) returns everything to reset values at the next edge. The pass is abandoned and a new rd_flag is required.
- Outputs are all registered. There is no combinational path from inputs to outputs.

## Test plan
- Clean pass: reset, pulse rd_flag, drive addr 0..63 on 64 consecutive cycles with RAM model data=addr (RD_LAT=1). Required: chk_done=1 and chk_pass=1 one cycle after the last compare; word_cnt=64; err_cnt=0.
- Single error: same pattern, but RAM returns 0xFF at addr 0x15. Required: err_cnt=1; err_addr=0x15; err_exp=0x15; err_got=0xFF; chk_pass=0; chk_done=1.
- First-error hold: corrupt addr 5 (0xAA) and addr 9 (0x00). Required: err_cnt=2; err_addr=5; err_exp=0x05; err_got=0xAA.
- Gapped reads with RD_LAT=2: ram_rd_en toggles every other cycle over 64 reads. Required: word_cnt=64, pass=1, and no sample counted at a disabled cycle. Reads issued before rd_flag are ignored (word_cnt stays 0 in IDLE).
- Reset mid-check: assert rst after 30 words. Required: all outputs 0 and state IDLE next cycle. A following rd_flag plus a 64-word clean pass gives pass=1 and word_cnt=64.
- Re-arm from DONE: after a failing pass, pulse rd_flag. Required: err_cnt/err_* clear the next cycle and chk_busy=1. A clean second pass ends with pass=1.
